// File: rtl/lr_binary_modexp.sv
// Left-to-right square-and-multiply modular exponentiator: r = base^exp mod modulus.
// Each modular product runs through a bit-serial interleaved multiplier, one multiplier bit per clock.
module lr_binary_modexp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             md_start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQR,
        MUL,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] e_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH+1:0] p;
    logic [CW-1:0]    j;
    logic [CW-1:0]    i;

    logic [WIDTH-1:0] y_op;
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] m_dbl;
    logic [WIDTH+1:0] p_dbl;
    logic [WIDTH+1:0] p_step;
    logic             last_step;
    logic             m_small;

    // One interleaved step: 2P plus the selected multiplicand stays below 3M,
    // so at most two conditional subtractions restore P < M.
    always_comb begin
        y_op      = (state == MUL) ? b_reg : acc;
        m_ext     = {2'b00, m_reg};
        m_dbl     = m_ext << 1;
        p_dbl     = (p << 1) + (acc[j] ? {2'b00, y_op} : '0);
        p_step    = p_dbl;
        if (p_dbl >= m_dbl) begin
            p_step = p_dbl - m_dbl;
        end else if (p_dbl >= m_ext) begin
            p_step = p_dbl - m_ext;
        end
        last_step = (j == '0);
        m_small   = (m_reg < WIDTH'(2));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The NEXT decision is folded into the last multiplier cycle, so a
    // square is followed directly by its multiply, the next square, or DONE.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (md_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                state_next = m_small ? DONE : SQR;
            end
            SQR: begin
                busy = 1'b1;
                if (last_step) begin
                    if (e_reg[i]) begin
                        state_next = MUL;
                    end else if (i == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = SQR;
                    end
                end
            end
            MUL: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = (i == '0) ? DONE : SQR;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            b_reg <= '0;
            e_reg <= '0;
            m_reg <= '0;
            acc   <= '0;
            p     <= '0;
            j     <= '0;
            i     <= '0;
            r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        b_reg <= base;
                        e_reg <= exp;
                        m_reg <= modulus;
                    end
                end
                LOAD: begin
                    acc <= WIDTH'(1);
                    p   <= '0;
                    j   <= CW'(WIDTH - 1);
                    i   <= CW'(WIDTH - 1);
                    if (m_small) begin
                        r <= '0;
                    end
                end
                SQR, MUL: begin
                    if (last_step) begin
                        acc <= p_step[WIDTH-1:0];
                        p   <= '0;
                        j   <= CW'(WIDTH - 1);
                        if (state_next == DONE) begin
                            r <= p_step[WIDTH-1:0];
                        end
                        if (state_next == SQR) begin
                            i <= i - CW'(1);
                        end
                    end else begin
                        p <= p_step;
                        j <= j - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lr_binary_modexp.sv
// Bench for lr_binary_modexp: known vectors, random operands against a right-to-left
// arithmetic model, latency, held start, and mid-operation reset.
module tb_lr_binary_modexp;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             md_start = 1'b0;
    logic [WIDTH-1:0] base = '0;
    logic [WIDTH-1:0] exp = '0;
    logic [WIDTH-1:0] modulus = '0;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    lr_binary_modexp #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rstn(rstn),
        .md_start(md_start),
        .base(base),
        .exp(exp),
        .modulus(modulus),
        .r(r),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] want;
    } vec_t;

    // Right-to-left binary exponentiation with wide integers.
    function automatic logic [WIDTH-1:0] model_modexp(input logic [WIDTH-1:0] b,
                                                      input logic [WIDTH-1:0] e,
                                                      input logic [WIDTH-1:0] m);
        longint unsigned res;
        longint unsigned sq;
        longint unsigned mm;
        if (m < 2) return '0;
        mm  = longint'(m);
        res = 1;
        sq  = longint'(b) % mm;
        for (int k = 0; k < WIDTH; k++) begin
            if (e[k]) res = (res * sq) % mm;
            sq = (sq * sq) % mm;
        end
        return res[WIDTH-1:0];
    endfunction

    function automatic int model_latency(input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] m);
        if (m < 2) return 2;
        return 2 + WIDTH * (WIDTH + $countones(e));
    endfunction

    task automatic check_output(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Starts one operation and waits for done; returns result and latency in cycles.
    task automatic apply_stimulus(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e,
                                  input logic [WIDTH-1:0] m, output logic [WIDTH-1:0] res,
                                  output int lat, output bit busy_ok, output bit timed_out);
        int st;
        @(negedge clk);
        base     = b;
        exp      = e;
        modulus  = m;
        md_start = 1'b1;
        st       = cyc;
        @(negedge clk);
        md_start  = 1'b0;
        busy_ok   = 1'b1;
        timed_out = 1'b1;
        for (int n = 0; n < 5000; n++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
        end
        lat = cyc - st;
        res = r;
    endtask

    task automatic run_and_check(input string tag, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] m,
                                 input logic [WIDTH-1:0] want);
        logic [WIDTH-1:0] res;
        int lat;
        bit busy_ok, timed_out;
        apply_stimulus(b, e, m, res, lat, busy_ok, timed_out);
        check_output({tag, " timeout"}, longint'(timed_out), 0);
        check_output({tag, " r"}, longint'(res), longint'(want));
        check_output({tag, " latency"}, lat, model_latency(e, m));
        check_output({tag, " busy"}, longint'(busy_ok), 1);
        check_output({tag, " busy at done"}, longint'(busy), 0);
        @(negedge clk);
        check_output({tag, " done pulse width"}, longint'(done), 0);
        check_output({tag, " r hold"}, longint'(r), longint'(want));
    endtask

    initial begin
        vec_t vecs[8];
        logic [WIDTH-1:0] rb, re, rm;
        int st, pulses, first_at, second_at;
        bit r_stable;

        vecs[0] = '{b: 4,    e: 13,   m: 497,  want: 445};
        vecs[1] = '{b: 65,   e: 17,   m: 3233, want: 2790};
        vecs[2] = '{b: 2790, e: 2753, m: 3233, want: 65};
        vecs[3] = '{b: 2,    e: 10,   m: 1000, want: 24};
        vecs[4] = '{b: 2,    e: 0,    m: 1000, want: 1};
        vecs[5] = '{b: 0,    e: 5,    m: 1000, want: 0};
        vecs[6] = '{b: 7,    e: 9,    m: 1,    want: 0};
        vecs[7] = '{b: 7,    e: 9,    m: 0,    want: 0};

        repeat (3) @(negedge clk);
        check_output("reset r", longint'(r), 0);
        check_output("reset busy", longint'(busy), 0);
        check_output("reset done", longint'(done), 0);
        rstn = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_and_check($sformatf("vec%0d", v), vecs[v].b, vecs[v].e, vecs[v].m, vecs[v].want);
        end

        for (int t = 0; t < 4; t++) begin
            rm = $urandom;
            if (rm < 2) rm = 32'd3;
            rb = $urandom % rm;
            re = $urandom;
            run_and_check($sformatf("rand%0d", t), rb, re, rm, model_modexp(rb, re, rm));
        end

        // Held start: one pulse per accepted start, restart only after DONE returns to IDLE.
        @(negedge clk);
        base     = 32'd2;
        exp      = 32'd10;
        modulus  = 32'd1000;
        md_start = 1'b1;
        st       = cyc;
        pulses   = 0;
        first_at = -1;
        second_at = -1;
        r_stable = 1'b1;
        for (int n = 0; n <= 2 * model_latency(32'd10, 32'd1000) + 1; n++) begin
            if (done) begin
                pulses++;
                if (first_at < 0) first_at = cyc - st;
                else second_at = cyc - st;
            end
            if (first_at >= 0 && r !== 32'd24) r_stable = 1'b0;
            @(negedge clk);
        end
        md_start = 1'b0;
        check_output("held start pulses", pulses, 2);
        check_output("held start first", first_at, model_latency(32'd10, 32'd1000));
        check_output("held start second", second_at, 2 * model_latency(32'd10, 32'd1000) + 1);
        check_output("held start r stable", longint'(r_stable), 1);
        repeat (WIDTH * (WIDTH + 2) + 4) @(negedge clk);
        check_output("held start idle", longint'(busy), 0);

        // Reset during the squaring phase of a long run.
        @(negedge clk);
        base     = 32'd4;
        exp      = 32'd13;
        modulus  = 32'd497;
        md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        repeat (100) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_output("abort r", longint'(r), 0);
        check_output("abort busy", longint'(busy), 0);
        check_output("abort done", longint'(done), 0);
        rstn = 1'b1;
        run_and_check("after abort", 32'd4, 32'd13, 32'd497, 32'd445);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
